dac_stream_if: RTL and testbench
================================

# dac_stream_if

Parametrised multi-channel parallel DAC interface for AD976x-class converters. Accepts samples through a valid/ready stream into a small FIFO and updates all DAC channels together at a programmable rate. Generates the DAC clock and write strobes, and converts two's-complement samples to offset binary when asked. Sits between the DDS/divider datapath and the DAC pins, and takes over from the fixed single-channel, one-sample-per-clock DAC driver.

## Interface
- DATA_W, 14, bits per DAC channel (2..16)
- CH, 2, number of DAC channels updated together (1..4)
- FIFO_DEPTH, 8, sample-FIFO entries; power of two, at least 2
- CLK_DIV, 2, system clocks per DAC update period; at least 2, even
- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  asynchronous reset, active-high
- en  in  1  run enable; when low the divider, the DAC clock and FIFO pops are frozen
- s_valid  in  1  input sample valid
- s_ready  out  1  FIFO can accept a sample
- s_data  in  CH*DATA_W  one sample per channel; channel k is bits [k*DATA_W +: DATA_W]
- s_fmt_twos  in  1  1 = s_data is two's complement, 0 = offset binary; sampled at pop
- clr_underrun  in  1  clears the underrun flag
- O_dac_clk  out  1  DAC clock
- O_dac_wrt  out  1  DAC write strobe; identical to O_dac_clk
- O_dac_data  out  CH*DATA_W  registered DAC data, offset binary
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- underrun  out  1  sticky flag; set when an update tick finds the FIFO empty

## Operation
- **Reset values:**
  - div_cnt = 0, O_dac_clk = O_dac_wrt = 0
  - every O_dac_data channel = midscale, 1<<(DATA_W-1)
  - FIFO empty, fifo_level = 0, underrun = 0
  - s_ready = 0 while rst is high, 1 from the first clock after release
- **Handshake:**
  - A push happens when s_valid && s_ready.
  - s_ready = !full. There is no push-through when full, even if a pop happens in the same cycle.
  - s_data is held by the source until accepted.
- **Divider:**
  - While en = 1, div_cnt counts 0..CLK_DIV-1 and wraps.
  - tick = en && div_cnt == CLK_DIV-1.
  - While en = 0, div_cnt and all outputs hold.
- **Update on tick:**
  - FIFO not empty: pop the head entry. O_dac_data takes each channel, with its MSB inverted if s_fmt_twos = 1.
  - FIFO empty: set underrun, and O_dac_data holds its last value.
- **Simultaneous events:**
  - Push and pop in the same cycle: fifo_level is unchanged.
  - Push into an empty FIFO on a tick cycle: the tick sees the FIFO as empty, so an underrun is recorded and the sample is popped at the next tick.
  - clr_underrun in the same cycle as a new underrun: set wins.
- **Pointers:** wrap modulo FIFO_DEPTH. fifo_level counts 0..FIFO_DEPTH.
- **Reset mid-operation:** every output returns to its reset value immediately and the FIFO contents are discarded.

## Timing
- O_dac_clk is registered.
  - Low while div_cnt < CLK_DIV/2, high otherwise, so the rising edge is mid-period.
  - O_dac_data changes only on the edge where div_cnt wraps to 0, which gives CLK_DIV/2 clk cycles of setup and of hold around the DAC rising edge.
- Latency: a sample pushed at cycle t into an empty FIFO appears on O_dac_data at the first tick edge at or after t+1. Worst case is t+CLK_DIV.
- Sustained throughput: one sample per CLK_DIV cycles. A source delivering at that rate with FIFO_DEPTH/2 samples preloaded never underruns.

## Configuration
- DAC_IF_UNDERRUN_MIDSCALE_EN:
  - Defined: an underrun tick drives every channel to midscale, 1<<(DATA_W-1).
  - Undefined: an underrun tick holds the last output value.
  - The underrun flag behaves identically in both builds.

## Test plan
- **Reset:** assert rst mid-stream with FIFO level 5 -> O_dac_data = 0x2000 per channel (DATA_W = 14), fifo_level = 0, underrun = 0, O_dac_clk = 0, s_ready = 0 until release.
- **Stream:** with defaults, push 0x0000, 0x1FFF, 0x2000, 0x3FFF on ch0 (ch1 = ch0) with s_fmt_twos = 0 -> the same values appear in order, one per 2 clk cycles, each changing while O_dac_clk is low.
- **Format:** with s_fmt_twos = 1, push 0x2000 (-8192) and 0x1FFF -> output is 0x0000 then 0x3FFF.
- **Full:** hold en = 0 and push 9 samples into a depth-8 FIFO -> s_ready drops after the 8th, fifo_level = 8, and the 9th is held until en = 1 and the first pop.
- **Underrun:** stop the source with the FIFO empty -> underrun = 1 at the next tick; output holds the last value (or 0x2000 with DAC_IF_UNDERRUN_MIDSCALE_EN); clr_underrun clears the flag unless the same cycle is an underrun tick.
- **Parametrisation:** CH = 4, DATA_W = 12, CLK_DIV = 4 -> all four channels update together every 4 cycles, and O_dac_clk is high for 2 of those 4 cycles.

Source files
------------

// File: rtl/dac_stream_if.sv
// Multi-channel parallel DAC interface: valid/ready sample FIFO, programmable update divider,
// DAC clock/write generation and optional two's-complement to offset-binary conversion.
// Build option: DAC_IF_UNDERRUN_MIDSCALE_EN drives midscale on an underrun tick instead of holding.
module dac_stream_if #(
   parameter int DATA_W     = 14,
   parameter int CH         = 2,
   parameter int FIFO_DEPTH = 8,
   parameter int CLK_DIV    = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [CH*DATA_W-1:0]         s_data,
   input  logic                         s_fmt_twos,
   input  logic                         clr_underrun,
   output logic                         O_dac_clk,
   output logic                         O_dac_wrt,
   output logic [CH*DATA_W-1:0]         O_dac_data,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
   output logic                         underrun
);
   localparam int W     = CH * DATA_W;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0]  DIV_HALF = DIV_W'(CLK_DIV / 2);
   localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(FIFO_DEPTH);
   localparam logic [DATA_W-1:0] MID      = {1'b1, {(DATA_W-1){1'b0}}};

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             dac_clk_q, dac_clk_d;
   logic [W-1:0]     data_q, data_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             und_q, und_d;
   logic             init_q, init_d;
   logic [W-1:0]     mem_q [FIFO_DEPTH];
   logic [W-1:0]     head, conv;
   logic             full, empty, push, pop, tick, und_set;

   assign full    = (level_q == LVL_FULL);
   assign empty   = (level_q == '0);
   assign s_ready = init_q && !full;
   assign push    = s_valid && s_ready;
   assign tick    = en && (div_cnt_q == DIV_LAST);
   // Emptiness is judged on the registered level, so a same-cycle push cannot satisfy a tick.
   assign pop     = tick && !empty;
   assign und_set = tick && empty;
   assign head    = mem_q[rd_ptr_q];

   for (genvar k = 0; k < CH; k++) begin : g_ch
      assign conv[k*DATA_W +: DATA_W] = {head[k*DATA_W+DATA_W-1] ^ s_fmt_twos,
                                         head[k*DATA_W +: DATA_W-1]};
   end

   always_comb begin
      div_cnt_d = div_cnt_q;
      if (en) div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
      // DAC clock rises mid-period so data (changing at wrap) has half a period of setup and hold.
      dac_clk_d = (div_cnt_d >= DIV_HALF);
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      level_d  = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
      und_d  = und_set ? 1'b1 : (clr_underrun ? 1'b0 : und_q);
      init_d = 1'b1;
   end

   always_comb begin
      data_d = data_q;
      if (pop) data_d = conv;
`ifdef DAC_IF_UNDERRUN_MIDSCALE_EN
      else if (und_set) data_d = {CH{MID}};
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_q <= '0;
         dac_clk_q <= 1'b0;
         data_q    <= {CH{MID}};
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         und_q     <= 1'b0;
         init_q    <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         dac_clk_q <= dac_clk_d;
         data_q    <= data_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         und_q     <= und_d;
         init_q    <= init_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= s_data;
   end

   assign O_dac_clk  = dac_clk_q;
   assign O_dac_wrt  = dac_clk_q;
   assign O_dac_data = data_q;
   assign fifo_level = level_q;
   assign underrun   = und_q;
endmodule

// File: tb/tb_dac_stream_if.sv
// Directed bench for dac_stream_if: default build (CH=2, DATA_W=14, CLK_DIV=2) plus a
// CH=4 / DATA_W=12 / CLK_DIV=4 instance for the parametrisation check.
module tb_dac_stream_if;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0, s_valid = 1'b0, s_fmt_twos = 1'b0, clr_underrun = 1'b0;
   logic        s_ready, dac_clk, dac_wrt, und;
   logic [27:0] s_data = '0, dac_data;
   logic [3:0]  lvl;

   logic        en4 = 1'b0, v4 = 1'b0, rdy4, clk4o, wrt4, und4;
   logic [47:0] d4 = '0, data4;
   logic [3:0]  lvl4;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dac_stream_if dut (
      .clk(clk), .rst(rst), .en(en), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_fmt_twos(s_fmt_twos), .clr_underrun(clr_underrun), .O_dac_clk(dac_clk),
      .O_dac_wrt(dac_wrt), .O_dac_data(dac_data), .fifo_level(lvl), .underrun(und));

   dac_stream_if #(.DATA_W(12), .CH(4), .FIFO_DEPTH(8), .CLK_DIV(4)) dut4 (
      .clk(clk), .rst(rst), .en(en4), .s_valid(v4), .s_ready(rdy4), .s_data(d4),
      .s_fmt_twos(1'b0), .clr_underrun(1'b0), .O_dac_clk(clk4o),
      .O_dac_wrt(wrt4), .O_dac_data(data4), .fifo_level(lvl4), .underrun(und4));

   typedef struct {
      logic [13:0] in0, in1;
      logic        fmt;
      logic [13:0] ex0, ex1;
   } vec_t;
   vec_t tbl [6];

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [27:0] fval(input int i);
      logic [13:0] a, b;
      a = 14'(i * 'h123);
      b = 14'(i + 'h100);
      return {b, a};
   endfunction

   localparam logic [27:0] MID2 = {14'h2000, 14'h2000};
   localparam logic [47:0] MID4 = {4{12'h800}};
   localparam logic [47:0] A4   = {12'h444, 12'h333, 12'h222, 12'h111};
   localparam logic [47:0] B4   = {12'hABC, 12'h123, 12'hFFF, 12'h000};

   initial begin
      logic [27:0] prev, hold;
      logic [3:0]  clk_pat;
      tbl[0] = '{14'h0000, 14'h3FFF, 1'b0, 14'h0000, 14'h3FFF};
      tbl[1] = '{14'h1FFF, 14'h2000, 1'b0, 14'h1FFF, 14'h2000};
      tbl[2] = '{14'h2000, 14'h1FFF, 1'b0, 14'h2000, 14'h1FFF};
      tbl[3] = '{14'h3FFF, 14'h0000, 1'b0, 14'h3FFF, 14'h0000};
      tbl[4] = '{14'h2000, 14'h1FFF, 1'b1, 14'h0000, 14'h3FFF};
      tbl[5] = '{14'h1FFF, 14'h2000, 1'b1, 14'h3FFF, 14'h0000};

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", s_ready, 0);
      chk("rst_data", dac_data, MID2);
      chk("rst_level", lvl, 0);
      chk("rst_underrun", und, 0);
      chk("rst_clk", dac_clk, 0);
      chk("rst_wrt", dac_wrt, 0);
      rst = 1'b0;
      step();
      chk("ready_after_release", s_ready, 1);

      // preload stream vectors with the divider frozen
      for (int i = 0; i < 6; i++) begin
         s_valid = 1'b1;
         s_data  = {tbl[i].in1, tbl[i].in0};
         step();
      end
      s_valid = 1'b0;
      chk("preload_level", lvl, 6);

      en   = 1'b1;
      prev = MID2;
      for (int i = 0; i < 6; i++) begin
         s_fmt_twos = tbl[i].fmt;
         step();
         chk("stream_clk_hi", dac_clk, 1);
         chk("stream_wrt_hi", dac_wrt, 1);
         chk("stream_hold", dac_data, prev);
         step();
         chk("stream_data", dac_data, {tbl[i].ex1, tbl[i].ex0});
         chk("stream_clk_lo", dac_clk, 0);
         chk("stream_level", lvl, 4'(5 - i));
         prev = {tbl[i].ex1, tbl[i].ex0};
      end
      s_fmt_twos = 1'b0;

      // underrun and clear
`ifdef DAC_IF_UNDERRUN_MIDSCALE_EN
      hold = MID2;
`else
      hold = prev;
`endif
      step();
      chk("und_before_tick", und, 0);
      step();
      chk("und_set", und, 1);
      chk("und_data", dac_data, hold);
      clr_underrun = 1'b1;
      step();
      chk("und_cleared", und, 0);
      step();
      chk("und_set_wins", und, 1);
      clr_underrun = 1'b0;

      // full FIFO with en low
      en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("full_ready_pre", s_ready, 1);
         s_valid = 1'b1;
         s_data  = fval(i);
         step();
      end
      chk("full_level", lvl, 8);
      chk("full_ready", s_ready, 0);
      s_data = fval(8);
      repeat (3) step();
      chk("full_hold_level", lvl, 8);
      en = 1'b1;
      step();
      chk("full_nopush_level", lvl, 8);
      chk("full_nopush_ready", s_ready, 0);
      step();
      chk("full_pop_level", lvl, 7);
      chk("full_pop_ready", s_ready, 1);
      chk("full_pop_data", dac_data, fval(0));
      for (int k = 1; k <= 8; k++) begin
         step();
         if (k == 1) begin
            chk("full_refill_level", lvl, 8);
            s_valid = 1'b0;
         end
         step();
         chk("full_drain_data", dac_data, fval(k));
      end

      // reset mid-stream with level 5
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         s_valid = 1'b1;
         s_data  = fval(i + 20);
         step();
      end
      s_valid = 1'b0;
      chk("mid_level5", lvl, 5);
      chk("mid_und_pending", und, 1);
      en = 1'b1;
      step();
      chk("mid_clk_hi", dac_clk, 1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_data", dac_data, MID2);
      chk("mid_rst_level", lvl, 0);
      chk("mid_rst_und", und, 0);
      chk("mid_rst_clk", dac_clk, 0);
      chk("mid_rst_ready", s_ready, 0);
      step();
      chk("mid_rst_ready_hold", s_ready, 0);
      #1 rst = 1'b0;
      en = 1'b0;
      step();
      chk("mid_release_ready", s_ready, 1);
      chk("mid_release_level", lvl, 0);

      // CH=4, DATA_W=12, CLK_DIV=4 instance
      v4 = 1'b1; d4 = A4; step();
      d4 = B4; step();
      v4 = 1'b0;
      chk("p4_level", lvl4, 2);
      en4 = 1'b1;
      clk_pat = 4'b0110;
      for (int k = 0; k < 8; k++) begin
         step();
         chk("p4_clk", clk4o, clk_pat[k % 4]);
         chk("p4_wrt", wrt4, clk_pat[k % 4]);
         chk("p4_data", data4, (k < 3) ? MID4 : ((k < 7) ? A4 : B4));
      end
      chk("p4_empty", lvl4, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
